inst_fetch_unit: RTL and testbench

Instruction fetch stage feeding the ID-stage control decoder. Holds the PC, issues word requests to instruction memory over a single-outstanding req/valid handshake, and buffers returned words in a small {pc, inst} queue. Presents one instruction per cycle to IF/ID under a stall input. On a taken branch (PC-mux select from ID) it redirects to the target, discards queued and in-flight words, and pulses a flush toward IF/ID.

---
 rtl/inst_fetch_unit.sv | 176 +++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem handshake and a small {pc, inst} queue toward IF/ID.
// Optional macro IFU_BYPASS_EN forwards a response straight to the outputs when the queue is empty.
module inst_fetch_unit #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_valid_i,
    input  logic [31:0] imem_data_i,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        inst_valid_o,
    output logic        flush_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   addr_q, addr_d;
    logic          req_q, req_d;
    logic          flush_q, flush_d;
    logic [31:0]   qinst_q [DEPTH];
    logic [31:0]   qpc_q   [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          accept_s, redirect_s, push_s, pop_s, bypass_s, head_valid_s;
    logic          unused_tgt_s;

    assign unused_tgt_s = ^branch_target_i[1:0];
    assign accept_s     = req_q && imem_valid_i && (state_q != S_IDLE);
    assign redirect_s   = branch_i && (state_q != S_IDLE);
    assign head_valid_s = (cnt_q != CW'(0));

`ifdef IFU_BYPASS_EN
    assign bypass_s = accept_s && (state_q == S_WAIT) && !head_valid_s && !branch_i && !stall_i;
`else
    assign bypass_s = 1'b0;
`endif

    assign push_s = accept_s && (state_q == S_WAIT) && !redirect_s && !bypass_s;
    // A redirect wins over consumption: the head is discarded, not delivered.
    assign pop_s  = head_valid_s && !stall_i && !redirect_s;

    assign imem_req_o  = req_q;
    assign imem_addr_o = addr_q;
    assign flush_o     = flush_q;

`ifdef IFU_BYPASS_EN
    assign inst_o       = bypass_s ? imem_data_i : qinst_q[rd_q];
    assign pc_o         = bypass_s ? addr_q      : qpc_q[rd_q];
    assign inst_valid_o = head_valid_s || bypass_s;
`else
    assign inst_o       = qinst_q[rd_q];
    assign pc_o         = qpc_q[rd_q];
    assign inst_valid_o = head_valid_s;
`endif

    // Fetch FSM: next state, request/address and fetch PC.
    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        addr_d  = addr_q;
        req_d   = req_q;
        flush_d = redirect_s;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_FETCH;
                else         state_d = S_IDLE;
            end
            S_FETCH: begin
                // The in-flight response always has a slot because we only ask while a slot is free.
                if (!redirect_s && (cnt_q < CW'(DEPTH))) begin
                    req_d   = 1'b1;
                    addr_d  = fpc_q;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WAIT: begin
                if (accept_s) begin
                    req_d   = 1'b0;
                    state_d = S_FETCH;
                    fpc_d   = fpc_q + 32'd4;
                end else if (redirect_s) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DRAIN: begin
                if (accept_s) begin
                    req_d   = 1'b0;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
        if (redirect_s) fpc_d = {branch_target_i[31:2], 2'b00};
        else            fpc_d = fpc_d;
    end

    // Queue pointer and occupancy update.
    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (redirect_s) begin
            rd_d  = AW'(0);
            wr_d  = AW'(0);
            cnt_d = CW'(0);
        end else begin
            if (push_s) wr_d = wr_q + AW'(1);
            else        wr_d = wr_q;
            if (pop_s)  rd_d = rd_q + AW'(1);
            else        rd_d = rd_q;
            case ({push_s, pop_s})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            fpc_q   <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            flush_q <= 1'b0;
            rd_q    <= AW'(0);
            wr_q    <= AW'(0);
            cnt_q   <= CW'(0);
            for (int i = 0; i < int'(DEPTH); i++) begin
                qinst_q[i] <= 32'h0000_0000;
                qpc_q[i]   <= 32'h0000_0000;
            end
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            flush_q <= flush_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            if (push_s) begin
                qinst_q[wr_q] <= imem_data_i;
                qpc_q[wr_q]   <= addr_q;
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit; a second instance checks PC wrap from RESET_PC=32'hFFFF_FFFC.
module tb_inst_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_i, start_i, imem_valid_i, stall_i, branch_i;
    logic [31:0] imem_data_i, branch_target_i;
    logic        req, valid, flush, req2, valid2, flush2;
    logic [31:0] addr, inst, pc, addr2, inst2, pc2;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    inst_fetch_unit #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .imem_req_o(req), .imem_addr_o(addr),
        .imem_valid_i(imem_valid_i), .imem_data_i(imem_data_i),
        .stall_i(stall_i), .branch_i(branch_i), .branch_target_i(branch_target_i),
        .inst_o(inst), .pc_o(pc), .inst_valid_o(valid), .flush_o(flush)
    );

    inst_fetch_unit #(.DEPTH(2), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .imem_req_o(req2), .imem_addr_o(addr2),
        .imem_valid_i(imem_valid_i), .imem_data_i(imem_data_i),
        .stall_i(stall_i), .branch_i(branch_i), .branch_target_i(branch_target_i),
        .inst_o(inst2), .pc_o(pc2), .inst_valid_o(valid2), .flush_o(flush2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i = 1'b0; start_i = 1'b0; imem_valid_i = 1'b0; stall_i = 1'b0;
        branch_i = 1'b0; imem_data_i = 32'h0; branch_target_i = 32'h0;
        tick(); tick();
        chk1 ("rst_req", req, 1'b0);
        chk32("rst_addr", addr, 32'h0000_0000);
        chk32("rst_inst", inst, 32'h0000_0000);
        chk32("rst_pc", pc, 32'h0000_0000);
        chk1 ("rst_valid", valid, 1'b0);
        chk1 ("rst_flush", flush, 1'b0);
        chk32("rst_addr2", addr2, 32'hFFFF_FFFC);

        // start, 1-cycle memory at 0,4,8
        rst_i = 1'b1; start_i = 1'b1;
        tick();
        chk1 ("fetch_entry_noreq", req, 1'b0);
        start_i = 1'b0;
        tick();
        chk1 ("req0", req, 1'b1);
        chk32("addr0", addr, 32'h0000_0000);
        chk32("addr0_wrap", addr2, 32'hFFFF_FFFC);
        imem_valid_i = 1'b1; imem_data_i = 32'h0000_0013;
        tick();
        imem_valid_i = 1'b0;
        chk1 ("valid0", valid, 1'b1);
        chk32("pc0", pc, 32'h0000_0000);
        chk32("inst0", inst, 32'h0000_0013);
        chk1 ("req_drop0", req, 1'b0);
        chk32("pc0_wrap", pc2, 32'hFFFF_FFFC);
        tick();
        chk1 ("req4", req, 1'b1);
        chk32("addr4", addr, 32'h0000_0004);
        chk32("addr4_wrap", addr2, 32'h0000_0000);
        chk1 ("popped0", valid, 1'b0);
        imem_valid_i = 1'b1;
        tick();
        imem_valid_i = 1'b0;
        chk1 ("valid4", valid, 1'b1);
        chk32("pc4", pc, 32'h0000_0004);
        tick();
        chk32("addr8", addr, 32'h0000_0008);
        imem_valid_i = 1'b1;
        tick();
        imem_valid_i = 1'b0;
        chk32("pc8", pc, 32'h0000_0008);
        chk1 ("valid8", valid, 1'b1);

        // stall: fill both slots, no requests once full
        stall_i = 1'b1;
        tick();
        chk1 ("req12", req, 1'b1);
        chk32("addr12", addr, 32'h0000_000C);
        chk32("hold_pc8", pc, 32'h0000_0008);
        imem_valid_i = 1'b1; imem_data_i = 32'hAAAA_0001;
        tick();
        imem_valid_i = 1'b0;
        tick(); tick(); tick(); tick();
        chk1 ("full_noreq", req, 1'b0);
        chk1 ("full_valid", valid, 1'b1);
        chk32("full_head", pc, 32'h0000_0008);
        stall_i = 1'b0;
        tick();
        chk32("pop_next_pc", pc, 32'h0000_000C);
        chk32("pop_next_inst", inst, 32'hAAAA_0001);
        chk1 ("pop_next_valid", valid, 1'b1);
        tick();
        chk1 ("empty_after_pops", valid, 1'b0);
        chk1 ("req16", req, 1'b1);
        chk32("addr16", addr, 32'h0000_0010);

        // branch while waiting on 16, target 0x102
        branch_i = 1'b1; branch_target_i = 32'h0000_0102;
        tick();
        branch_i = 1'b0;
        chk1 ("br_flush", flush, 1'b1);
        chk1 ("br_valid", valid, 1'b0);
        chk1 ("drain_req_held", req, 1'b1);
        chk32("drain_addr_held", addr, 32'h0000_0010);
        imem_valid_i = 1'b1; imem_data_i = 32'hDEAD_BEEF;
        tick();
        imem_valid_i = 1'b0;
        chk1 ("flush_one_cycle", flush, 1'b0);
        chk1 ("drain_discard", valid, 1'b0);
        chk1 ("drain_req_drop", req, 1'b0);
        tick();
        chk1 ("req_target", req, 1'b1);
        chk32("addr_target", addr, 32'h0000_0100);

        // branch and response in the same cycle
        branch_i = 1'b1; branch_target_i = 32'h0000_0200;
        imem_valid_i = 1'b1; imem_data_i = 32'hBEEF_0000;
        tick();
        branch_i = 1'b0; imem_valid_i = 1'b0;
        chk1 ("same_nopush", valid, 1'b0);
        chk1 ("same_flush", flush, 1'b1);
        chk1 ("same_req_drop", req, 1'b0);
        tick();
        chk1 ("same_req", req, 1'b1);
        chk32("same_addr", addr, 32'h0000_0200);
        imem_valid_i = 1'b1; imem_data_i = 32'h0000_0513;
        tick();
        imem_valid_i = 1'b0;
        chk32("tgt_pc", pc, 32'h0000_0200);
        chk32("tgt_inst", inst, 32'h0000_0513);
        tick();
        chk32("addr204", addr, 32'h0000_0204);

        // reset during WAIT with memory responding through and after reset
        rst_i = 1'b0; imem_valid_i = 1'b1; imem_data_i = 32'h1234_5678;
        tick();
        chk1 ("mid_rst_req", req, 1'b0);
        chk32("mid_rst_addr", addr, 32'h0000_0000);
        chk1 ("mid_rst_valid", valid, 1'b0);
        chk32("mid_rst_pc", pc, 32'h0000_0000);
        chk32("mid_rst_inst", inst, 32'h0000_0000);
        chk1 ("mid_rst_flush", flush, 1'b0);
        chk32("mid_rst_addr2", addr2, 32'hFFFF_FFFC);
        rst_i = 1'b1;
        tick();
        imem_valid_i = 1'b0;
        chk1 ("post_rst_nopush", valid, 1'b0);
        chk1 ("post_rst_idle", req, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
